seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
//
// PURPOSE
//   Multi-cycle, parametrised adder. Adds two W-bit operands K bits per clock,
//   with a registered carry between chunks, so the carry chain is only K bits long.
//   It generalises the combinational ripple-carry adder for wide operands where
//   a W-bit chain will not close timing.
//   Valid/ready handshake on both input and output; sits between datapath stages.
//
// PARAMETERS
//   W    16   operand/sum width in bits; W % K must be 0
//   K     4   chunk width added per cycle; 1 <= K <= W
//   NCH  W/K  localparam: chunks (cycles) per operation
//
// PORTS
//   clk        in   1   single clock, all state updates on rising edge
//   rst_n      in   1   synchronous, active-low reset
//   in_valid   in   1   operands a/b/ci (and op) valid
//   in_ready   out  1   block can accept an operation
//   a          in   W   operand A
//   b          in   W   operand B
//   ci         in   1   carry in
//   op         in   1   only with SUB_EN: 0 = add, 1 = subtract
//   out_valid  out  1   s/co hold a completed result
//   out_ready  in   1   consumer accepts result
//   s          out  W   sum
//   co         out  1   carry out (with op=1: 1 = no borrow)
//
// BEHAVIOUR
//   - Reset (rst_n=0 at an edge): state=IDLE, idx=0, carry=0, s=0, co=0,
//     out_valid=0, in_ready=1. Reset overrides everything, including mid-RUN and
//     DONE; the in-flight result is discarded and never presented.
//   - FSM IDLE:
//     - in_ready=1.
//     - On in_valid&&in_ready: latch a, b, op; carry=ci (or ~ci when op=1);
//       idx=0; go to RUN.
//   - FSM RUN:
//     - in_ready=0, out_valid=0.
//     - Each cycle: {c, s[idx*K +: K]} = a_chunk + b_chunk' + carry.
//       b_chunk' = ~b_chunk when op=1, else b_chunk.
//     - Then carry=c, idx=idx+1.
//     - At idx==NCH-1: write the last chunk, set co=c, go to DONE.
//   - FSM DONE:
//     - out_valid=1, in_ready=0; s and co held stable.
//     - On out_ready: go to IDLE and deassert out_valid on that edge.
//   - Latency: out_valid rises exactly NCH edges after the accepting edge.
//     Minimum issue interval is NCH+2 cycles, because there is no accept in DONE.
//   - Input changes while in RUN or DONE are ignored (operands registered).
//     in_valid while in_ready=0 is not consumed; the producer holds it.
//   - K==W: NCH=1, one RUN cycle. idx width = max(1, clog2(NCH)).
//   - Arithmetic is modulo 2^W; co is bit W of a + b' + cin.
//   - s keeps the last result in IDLE until overwritten chunk-by-chunk.
//
// CONFIGURATION
//   SEQ_CHUNK_ADDER_SUB_EN defined:
//     - port op present.
//     - op=1 computes {co,s} = a + ~b + ~ci, i.e. a - b - ci, co=1 means no borrow.
//   Not defined:
//     - port op absent; op is internally tied to 0 (add only).
//
// TESTING
//   1. rst_n=0 for 2 edges mid-anything -> out_valid=0, s=0, co=0, in_ready=1.
//   2. W=16,K=4: a=0xFFFF, b=0x0001, ci=0 -> out_valid 4 edges after accept,
//      s=0x0000, co=1 (carry crosses all chunks).
//   3. out_ready=0 for 5 cycles in DONE -> s, co, out_valid stable; in_ready=0;
//      a concurrent in_valid with new operands is not accepted.
//   4. rst_n=0 after 2 RUN cycles of a=0x1234, b=0x4321 -> IDLE next edge;
//      out_valid never asserts for that operation.
//   5. W=4,K=2, exhaustive a,b in 0..15, ci in 0..1 -> {co,s}==a+b+ci;
//      repeat with K=1 and K=4.
//   6. SUB_EN, W=16,K=4: op=1, a=0x0005, b=0x0007, ci=0 -> s=0xFFFE, co=0;
//      a=0x0007, b=0x0005 -> s=0x0002, co=1.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Handshake bundle for seq_chunk_adder: operand side (in_*) and result side (out_*).
// The op field exists only when SEQ_CHUNK_ADDER_SUB_EN is defined.
interface seq_chunk_adder_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic         op;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  modport master (output in_valid, a, b, ci, op, out_ready,
                  input  in_ready, out_valid, s, co);
  modport slave  (input  in_valid, a, b, ci, op, out_ready,
                  output in_ready, out_valid, s, co);
`else
  modport master (output in_valid, a, b, ci, out_ready,
                  input  in_ready, out_valid, s, co);
  modport slave  (input  in_valid, a, b, ci, out_ready,
                  output in_ready, out_valid, s, co);
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: sums two W-bit operands K bits per clock with a registered carry.
// Define SEQ_CHUNK_ADDER_SUB_EN to add the op input (1 = a - b - ci).
module seq_chunk_adder #(
  parameter int W = 16,
  parameter int K = 4
) (
  input logic             clk,
  input logic             rst_n,
  seq_chunk_adder_if.slave bus
);

  localparam int NCH = W / K;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  s_r;
  logic          op_r;
  logic          carry;
  logic          co_r;

  logic          op_in;
  logic          in_ready_c;
  logic          out_valid_c;
  logic          accept;
  logic          last;
  logic [K-1:0]  a_ch;
  logic [K-1:0]  b_ch;
  logic [K:0]    sum_ch;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  assign op_in = bus.op;
`else
  assign op_in = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.s         = s_r;
  assign bus.co        = co_r;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction reuses the adder: invert b per chunk and invert the incoming carry.
  always_comb begin
    a_ch   = a_r[int'(idx) * K +: K];
    b_ch   = op_r ? ~b_r[int'(idx) * K +: K] : b_r[int'(idx) * K +: K];
    sum_ch = {1'b0, a_ch} + {1'b0, b_ch} + {{K{1'b0}}, carry};
    last   = (idx == IW'(NCH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      op_r  <= 1'b0;
      carry <= 1'b0;
      co_r  <= 1'b0;
    end else begin
      if (accept) begin
        a_r   <= bus.a;
        b_r   <= bus.b;
        op_r  <= op_in;
        carry <= op_in ? ~bus.ci : bus.ci;
        idx   <= '0;
      end else if (state == RUN) begin
        s_r[int'(idx) * K +: K] <= sum_ch[K-1:0];
        carry <= sum_ch[K];
        idx   <= idx + 1'b1;
        if (last) co_r <= sum_ch[K];
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: W=16/K=4 handshake scenarios plus exhaustive W=4 sweeps.
// Build with SEQ_CHUNK_ADDER_SUB_EN defined to also exercise subtraction.
module tb_seq_chunk_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_chunk_adder_if #(.W(16)) bus16 ();
  seq_chunk_adder_if #(.W(4))  bus4k1 ();
  seq_chunk_adder_if #(.W(4))  bus4k2 ();
  seq_chunk_adder_if #(.W(4))  bus4k4 ();

  seq_chunk_adder #(.W(16), .K(4)) dut16  (.clk(clk), .rst_n(rst_n), .bus(bus16));
  seq_chunk_adder #(.W(4),  .K(1)) dut4k1 (.clk(clk), .rst_n(rst_n), .bus(bus4k1));
  seq_chunk_adder #(.W(4),  .K(2)) dut4k2 (.clk(clk), .rst_n(rst_n), .bus(bus4k2));
  seq_chunk_adder #(.W(4),  .K(4)) dut4k4 (.clk(clk), .rst_n(rst_n), .bus(bus4k4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.s !== 16'h0 || bus16.co !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got rdy=%b vld=%b s=%h co=%b expected rdy=1 vld=0 s=0000 co=0",
               bus16.in_ready, bus16.out_valid, bus16.s, bus16.co);
    end
    checks++;
    if (bus4k1.in_ready !== 1'b1 || bus4k2.out_valid !== 1'b0 || bus4k4.s !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_state_w4 got rdy=%b vld=%b s=%h expected rdy=1 vld=0 s=0",
               bus4k1.in_ready, bus4k2.out_valid, bus4k4.s);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain;
    int lat;
    lat = -1;
    @(negedge clk);
    bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.ci = 1'b0;
    bus16.out_ready = 1'b1; bus16.in_valid = 1'b1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    for (int c = 0; c < 12 && lat < 0; c++) begin
      @(negedge clk);
      if (bus16.out_valid === 1'b1) begin
        lat = c;
        checks++;
        if (bus16.s !== 16'h0000 || bus16.co !== 1'b1) begin
          errors++;
          $display("[TB] FAIL carry_chain got s=%h co=%b expected s=0000 co=1", bus16.s, bus16.co);
        end
      end
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL carry_latency got %0d expected 4", lat);
    end
  endtask

  task automatic test_hold_in_done;
    bit found;
    found = 1'b0;
    @(negedge clk);
    bus16.a = 16'h00FF; bus16.b = 16'h0F01; bus16.ci = 1'b1;
    bus16.out_ready = 1'b0; bus16.in_valid = 1'b1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (bus16.out_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL hold_reach_done got out_valid=0 expected 1 within 12 cycles");
    end
    bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.ci = 1'b0; bus16.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 || bus16.s !== 16'h1001 || bus16.co !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_stable cyc %0d got vld=%b rdy=%b s=%h co=%b expected vld=1 rdy=0 s=1001 co=0",
                 c, bus16.out_valid, bus16.in_ready, bus16.s, bus16.co);
      end
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.s !== 16'h1001) begin
      errors++;
      $display("[TB] FAIL hold_release got vld=%b rdy=%b s=%h expected vld=0 rdy=1 s=1001",
               bus16.out_valid, bus16.in_ready, bus16.s);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.ci = 1'b0;
    bus16.out_ready = 1'b1; bus16.in_valid = 1'b1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.s !== 16'h0 || bus16.co !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run got rdy=%b vld=%b s=%h co=%b expected rdy=1 vld=0 s=0000 co=0",
               bus16.in_ready, bus16.out_valid, bus16.s, bus16.co);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus16.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL reset_discard got out_valid seen=1 expected 0");
    end
  endtask

  task automatic test_reset_in_done;
    @(negedge clk);
    bus16.a = 16'h0101; bus16.b = 16'h0202; bus16.ci = 1'b0;
    bus16.out_ready = 1'b0; bus16.in_valid = 1'b1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (bus16.out_valid !== 1'b1 || bus16.s !== 16'h0303) begin
      errors++;
      $display("[TB] FAIL done_before_reset got vld=%b s=%h expected vld=1 s=0303", bus16.out_valid, bus16.s);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus16.out_ready = 1'b1;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.s !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_in_done got vld=%b rdy=%b s=%h expected vld=0 rdy=1 s=0000",
               bus16.out_valid, bus16.in_ready, bus16.s);
    end
  endtask

  // Operands switch to the second pair while the first is in flight; that change must be ignored.
  task automatic test_back_to_back;
    int first_c;
    int second_c;
    first_c  = -1;
    second_c = -1;
    @(negedge clk);
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.ci = 1'b1;
    bus16.out_ready = 1'b1; bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.a = 16'h8000; bus16.b = 16'h8000; bus16.ci = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus16.out_valid === 1'b1) begin
        if (first_c < 0) begin
          first_c = c;
          checks++;
          if (bus16.s !== 16'h3334 || bus16.co !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_first got s=%h co=%b expected s=3334 co=0", bus16.s, bus16.co);
          end
        end else if (second_c < 0) begin
          second_c = c;
          checks++;
          if (bus16.s !== 16'h0000 || bus16.co !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second got s=%h co=%b expected s=0000 co=1", bus16.s, bus16.co);
          end
        end
      end
      if (c == 6) bus16.in_valid = 1'b0;
    end
    checks++;
    if (first_c != 4 || second_c != 10) begin
      errors++;
      $display("[TB] FAIL b2b_timing got first=%0d second=%0d expected first=4 second=10", first_c, second_c);
    end
  endtask

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  task automatic test_sub;
    logic [15:0] av [2];
    logic [15:0] bv [2];
    logic [15:0] sv [2];
    logic        cv [2];
    av[0] = 16'h0005; bv[0] = 16'h0007; sv[0] = 16'hFFFE; cv[0] = 1'b0;
    av[1] = 16'h0007; bv[1] = 16'h0005; sv[1] = 16'h0002; cv[1] = 1'b1;
    for (int v = 0; v < 2; v++) begin
      bit found;
      found = 1'b0;
      @(negedge clk);
      bus16.a = av[v]; bus16.b = bv[v]; bus16.ci = 1'b0; bus16.op = 1'b1;
      bus16.out_ready = 1'b1; bus16.in_valid = 1'b1;
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
        @(negedge clk);
        if (bus16.out_valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || bus16.s !== sv[v] || bus16.co !== cv[v]) begin
        errors++;
        $display("[TB] FAIL sub_%0d got valid=%b s=%h co=%b expected valid=1 s=%h co=%b",
                 v, found, bus16.s, bus16.co, sv[v], cv[v]);
      end
    end
    bus16.op = 1'b0;
  endtask
`endif

  // All three W=4 instances accept the same vector on the same edge; each must finish after its own NCH.
  task automatic test_exhaustive_w4;
    int          l1, l2, l4;
    logic [4:0]  r1, r2, r4, exp_sum;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          bus4k1.a = 4'(ia); bus4k1.b = 4'(ib); bus4k1.ci = ic[0]; bus4k1.in_valid = 1'b1;
          bus4k2.a = 4'(ia); bus4k2.b = 4'(ib); bus4k2.ci = ic[0]; bus4k2.in_valid = 1'b1;
          bus4k4.a = 4'(ia); bus4k4.b = 4'(ib); bus4k4.ci = ic[0]; bus4k4.in_valid = 1'b1;
          exp_sum = 5'(ia + ib + ic);
          l1 = -1; l2 = -1; l4 = -1;
          r1 = '0; r2 = '0; r4 = '0;
          @(posedge clk);
          #1;
          bus4k1.in_valid = 1'b0; bus4k2.in_valid = 1'b0; bus4k4.in_valid = 1'b0;
          for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (bus4k1.out_valid === 1'b1 && l1 < 0) begin l1 = c; r1 = {bus4k1.co, bus4k1.s}; end
            if (bus4k2.out_valid === 1'b1 && l2 < 0) begin l2 = c; r2 = {bus4k2.co, bus4k2.s}; end
            if (bus4k4.out_valid === 1'b1 && l4 < 0) begin l4 = c; r4 = {bus4k4.co, bus4k4.s}; end
          end
          checks++;
          if (l1 != 4 || r1 !== exp_sum) begin
            errors++;
            $display("[TB] FAIL w4k1 a=%0d b=%0d ci=%0d got sum=%h lat=%0d expected sum=%h lat=4",
                     ia, ib, ic, r1, l1, exp_sum);
          end
          checks++;
          if (l2 != 2 || r2 !== exp_sum) begin
            errors++;
            $display("[TB] FAIL w4k2 a=%0d b=%0d ci=%0d got sum=%h lat=%0d expected sum=%h lat=2",
                     ia, ib, ic, r2, l2, exp_sum);
          end
          checks++;
          if (l4 != 1 || r4 !== exp_sum) begin
            errors++;
            $display("[TB] FAIL w4k4 a=%0d b=%0d ci=%0d got sum=%h lat=%0d expected sum=%h lat=1",
                     ia, ib, ic, r4, l4, exp_sum);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus16.in_valid  = 1'b0; bus16.a  = '0; bus16.b  = '0; bus16.ci  = 1'b0; bus16.out_ready  = 1'b1;
    bus4k1.in_valid = 1'b0; bus4k1.a = '0; bus4k1.b = '0; bus4k1.ci = 1'b0; bus4k1.out_ready = 1'b1;
    bus4k2.in_valid = 1'b0; bus4k2.a = '0; bus4k2.b = '0; bus4k2.ci = 1'b0; bus4k2.out_ready = 1'b1;
    bus4k4.in_valid = 1'b0; bus4k4.a = '0; bus4k4.b = '0; bus4k4.ci = 1'b0; bus4k4.out_ready = 1'b1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    bus16.op = 1'b0; bus4k1.op = 1'b0; bus4k2.op = 1'b0; bus4k4.op = 1'b0;
`endif
    $display("[TB] starting seq_chunk_adder bench");
    test_reset();
    test_carry_chain();
    test_hold_in_done();
    test_reset_mid_run();
    test_reset_in_done();
    test_back_to_back();
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    test_sub();
`endif
    test_exhaustive_w4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
